filter_table_ctrl: RTL

Access sequencer and arbiter for the filter's 256 x 24 coefficient table RAM. The block takes APB table accesses decoded by the filter register block (TABLE_ADDR, TABLE_WR/WRINC/WRDEC_DATA, TABLE_RD/RDINC/RDDEC_DATA, TABLE_CFG.DIRECT) and schedules them against coefficient fetches from the filter datapath on a single-port RAM. It owns the table address pointer, including post-increment and post-decrement. It stretches the APB access until the RAM cycle completes.

---
 rtl/filter_table_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/filter_table_ctrl.sv
// rtl/filter_table_ctrl.sv - coefficient table RAM sequencer: APB pointer access vs filter fetch arbitration
module filter_table_ctrl #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_req,
  input  logic [2:0]        acc_op,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_done,
  output logic [DATA_W-1:0] acc_rdata,
  input  logic              addr_wr,
  input  logic [ADDR_W-1:0] addr_wdata,
  output logic [ADDR_W-1:0] addr_q,
  input  logic              direct,
  output logic              busy,
  input  logic              filt_req,
  input  logic [ADDR_W-1:0] filt_addr,
  output logic              filt_gnt,
  output logic              filt_rvalid,
  output logic [DATA_W-1:0] filt_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, PEND, RESP, DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_hold;
  logic [WW-1:0]     wait_cnt;
  logic              apb_win;

  // op_q[2] selects read; op_q[1:0] selects none / post-inc / post-dec
  assign apb_win = (state == PEND) && (direct || !filt_req || wait_cnt == WW'(MAX_WAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc_req) state_nx = PEND;
      PEND:    if (apb_win) state_nx = RESP;
      RESP:    state_nx = op_q[2] ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    filt_gnt  = filt_req && !direct && !apb_win;
    busy      = (state != IDLE);
    acc_done  = (state == DONE) || (state == RESP && !op_q[2]);
    ram_cs    = apb_win || filt_gnt;
    ram_we    = apb_win && !op_q[2];
    ram_addr  = apb_win ? addr_q : filt_addr;
    ram_wdata = wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= '0;
      wdata_q     <= '0;
      wait_cnt    <= '0;
      addr_q      <= '0;
      acc_rdata   <= '0;
      filt_rvalid <= 1'b0;
      rdata_hold  <= '0;
    end else begin
      if (state == IDLE && acc_req) begin
        op_q    <= acc_op;
        wdata_q <= acc_wdata;
      end
      if (state == PEND && !apb_win) wait_cnt <= wait_cnt + WW'(1);
      else                           wait_cnt <= '0;
      // a register write to the pointer beats the post-increment/decrement
      if (addr_wr)                          addr_q <= addr_wdata;
      else if (apb_win && op_q[1:0] == 2'd1) addr_q <= addr_q + ADDR_W'(1);
      else if (apb_win && op_q[1:0] == 2'd2) addr_q <= addr_q - ADDR_W'(1);
      if (state == RESP && op_q[2]) acc_rdata <= ram_rdata;
      filt_rvalid <= filt_gnt;
      if (filt_rvalid) rdata_hold <= ram_rdata;
    end
  end

  assign filt_rdata = filt_rvalid ? ram_rdata : rdata_hold;

endmodule
